later_data_csc_encoder: RTL and testbench

LATER_DATA_CSC_ENCODER -- requirements
Module: later_data_csc_encoder

---
 rtl/later_data_csc_encoder_if.sv | 31 +++
 rtl/later_data_csc_encoder.sv | 147 ++++++++++++++
 tb/tb_later_data_csc_encoder.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/later_data_csc_encoder_if.sv
// Handshake bundle between the dense INT-8 producer, the CSC encoder and the destination spad.
interface later_data_csc_encoder_if #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned COUNT_WIDTH = 4,
    parameter int unsigned ADDR_WIDTH  = 7
);
    logic                               start;
    logic [COUNT_WIDTH-1:0]             cfg_row_max;
    logic                               in_valid;
    logic                               in_ready;
    logic [DATA_WIDTH-1:0]              in_data;
    logic                               in_last;
    logic                               out_valid;
    logic                               out_ready;
    logic [DATA_WIDTH+COUNT_WIDTH-1:0]  out_data;
    logic                               addr_valid;
    logic [ADDR_WIDTH-1:0]              addr_data;
    logic                               done;
    logic                               overflow;
    logic                               busy;

    modport master (
        output start, cfg_row_max, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, addr_valid, addr_data, done, overflow, busy
    );

    modport slave (
        input  start, cfg_row_max, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, addr_valid, addr_data, done, overflow, busy
    );
endinterface

// File: rtl/later_data_csc_encoder.sv
// Compresses a column-major dense INT-8 matrix into CSC words {data,row} for a spad,
// reporting column end pointers and closing each matrix with a zero terminator word.
module later_data_csc_encoder #(
    parameter int unsigned SPAD_DEPTH  = 100,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned COUNT_WIDTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    later_data_csc_encoder_if.slave bus
);
    localparam int unsigned ADDR_WIDTH = $clog2(SPAD_DEPTH);
    localparam int unsigned WORD_WIDTH = DATA_WIDTH + COUNT_WIDTH;
    // One spad slot is always kept back for the terminator.
    localparam logic [ADDR_WIDTH-1:0] NZ_MAX = ADDR_WIDTH'(SPAD_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENCODE = 2'd1,
        TERM   = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] row_max_q, row_max_d;
    logic [COUNT_WIDTH-1:0] row_cnt_q, row_cnt_d;
    logic [ADDR_WIDTH-1:0]  nz_cnt_q, nz_cnt_d;
    logic                   out_valid_q, out_valid_d;
    logic [WORD_WIDTH-1:0]  out_data_q, out_data_d;
    logic                   addr_valid_q, addr_valid_d;
    logic [ADDR_WIDTH-1:0]  addr_data_q, addr_data_d;
    logic                   done_q, done_d;
    logic                   overflow_q, overflow_d;
    logic                   term_pend_q, term_pend_d;

    logic in_ready_c;
    logic in_fire_c;
    logic out_fire_c;
    logic col_end_c;
    logic nonzero_c;

    // The output register may be refilled in the same cycle its word is taken.
    assign in_ready_c = (state_q == ENCODE) & (~out_valid_q | bus.out_ready);
    assign in_fire_c  = bus.in_valid & in_ready_c;
    assign out_fire_c = out_valid_q & bus.out_ready;
    assign col_end_c  = (row_cnt_q == row_max_q) | bus.in_last;
    assign nonzero_c  = (bus.in_data != '0);

    always_comb begin
        state_d      = state_q;
        row_max_d    = row_max_q;
        row_cnt_d    = row_cnt_q;
        nz_cnt_d     = nz_cnt_q;
        out_valid_d  = out_valid_q & ~bus.out_ready;
        out_data_d   = out_data_q;
        addr_valid_d = 1'b0;
        addr_data_d  = addr_data_q;
        done_d       = 1'b0;
        overflow_d   = overflow_q;
        term_pend_d  = term_pend_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    row_max_d   = bus.cfg_row_max;
                    row_cnt_d   = '0;
                    nz_cnt_d    = '0;
                    overflow_d  = 1'b0;
                    term_pend_d = 1'b0;
                    state_d     = ENCODE;
                end
            end
            ENCODE: begin
                if (in_fire_c) begin
                    if (nonzero_c) begin
                        if (nz_cnt_q != NZ_MAX) begin
                            out_valid_d = 1'b1;
                            out_data_d  = {bus.in_data, row_cnt_q};
                            nz_cnt_d    = nz_cnt_q + ADDR_WIDTH'(1);
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                    row_cnt_d = col_end_c ? '0 : row_cnt_q + COUNT_WIDTH'(1);
                    if (col_end_c) begin
                        addr_valid_d = 1'b1;
                        addr_data_d  = nz_cnt_d;
                    end
                    if (bus.in_last) begin
                        term_pend_d = 1'b1;
                        state_d     = TERM;
                    end
                end
            end
            TERM: begin
                // First queue the terminator, then wait for the spad to take it.
                if (term_pend_q) begin
                    if (~out_valid_q | bus.out_ready) begin
                        out_valid_d = 1'b1;
                        out_data_d  = '0;
                        term_pend_d = 1'b0;
                    end
                end else if (out_fire_c) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            row_max_q    <= '0;
            row_cnt_q    <= '0;
            nz_cnt_q     <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            addr_valid_q <= 1'b0;
            addr_data_q  <= '0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            term_pend_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_max_q    <= row_max_d;
            row_cnt_q    <= row_cnt_d;
            nz_cnt_q     <= nz_cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            addr_valid_q <= addr_valid_d;
            addr_data_q  <= addr_data_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
            term_pend_q  <= term_pend_d;
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.addr_valid = addr_valid_q;
    assign bus.addr_data  = addr_data_q;
    assign bus.done       = done_q;
    assign bus.overflow   = overflow_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_later_data_csc_encoder.sv
// Directed bench for the CSC encoder: hand-computed word, pointer and flag expectations.
module tb_later_data_csc_encoder;
    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    later_data_csc_encoder_if #(.DATA_WIDTH(8), .COUNT_WIDTH(4), .ADDR_WIDTH(7)) bus ();

    later_data_csc_encoder #(.SPAD_DEPTH(100), .DATA_WIDTH(8), .COUNT_WIDTH(4)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    logic [31:0] words[$];
    logic [31:0] addrs[$];
    int done_cnt = 0;
    bit toggle_ready = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Spad-side monitor; also checks that no new value is accepted while a word is held.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (bus.out_valid && bus.out_ready) words.push_back(32'(bus.out_data));
            if (bus.addr_valid) addrs.push_back(32'(bus.addr_data));
            if (bus.done) done_cnt++;
            if (bus.out_valid && !bus.out_ready) check_eq("in_ready_while_held", 32'(bus.in_ready), 32'd0);
        end
    end

    always @(posedge clk_i) begin
        #1;
        if (toggle_ready) bus.out_ready = ~bus.out_ready;
    end

    task automatic pulse_start(input logic [3:0] rm);
        @(posedge clk_i); #1;
        bus.start = 1'b1;
        bus.cfg_row_max = rm;
        @(posedge clk_i); #1;
        bus.start = 1'b0;
    endtask

    task automatic send(input logic [7:0] v, input logic last);
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        bus.in_last  = last;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk_i);
            if (bus.in_ready) ok = 1'b1;
            @(posedge clk_i); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (!ok) check_eq("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_matrix(input logic [3:0] rm, input logic [7:0] vals[$]);
        pulse_start(rm);
        foreach (vals[i]) send(vals[i], (i == vals.size() - 1));
    endtask

    task automatic wait_done(input string tag, input int n);
        for (int i = 0; i < 2000 && done_cnt < n; i++) @(negedge clk_i);
        repeat (3) @(negedge clk_i);
        check_eq(tag, 32'(done_cnt), 32'(n));
    endtask

    task automatic check_seq(input string tag, input logic [31:0] got[$], input logic [31:0] exp[$]);
        check_eq({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
        foreach (exp[i]) begin
            if (i < got.size()) check_eq($sformatf("%s_%0d", tag, i), got[i], exp[i]);
        end
    endtask

    task automatic clear_logs();
        words.delete();
        addrs.delete();
        done_cnt = 0;
    endtask

    initial begin
        logic [7:0] stim[$];
        logic [31:0] exp_w[$];
        logic [31:0] exp_a[$];

        bus.start = 1'b0; bus.cfg_row_max = '0; bus.in_valid = 1'b0;
        bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b1;

        // Reset values
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("rst_out_valid", 32'(bus.out_valid), 0);
        check_eq("rst_out_data", 32'(bus.out_data), 0);
        check_eq("rst_in_ready", 32'(bus.in_ready), 0);
        check_eq("rst_addr", 32'({bus.addr_valid, bus.addr_data}), 0);
        check_eq("rst_flags", 32'({bus.done, bus.overflow, bus.busy}), 0);
        @(posedge clk_i); #1 rst_ni = 1'b1;

        // Basic 4x2 matrix, spad always ready
        stim = '{8'd5, 8'd0, 8'd0, 8'hFE, 8'd0, 8'd7, 8'd0, 8'd0};
        exp_w = '{32'h050, 32'hFE3, 32'h071, 32'h000};
        exp_a = '{32'd2, 32'd3};
        clear_logs();
        run_matrix(4'd3, stim);
        wait_done("A_done", 1);
        check_seq("A_words", words, exp_w);
        check_seq("A_addr", addrs, exp_a);
        check_eq("A_busy", 32'(bus.busy), 0);

        // Same matrix with a stalling spad
        clear_logs();
        toggle_ready = 1'b1;
        run_matrix(4'd3, stim);
        wait_done("B_done", 1);
        toggle_ready = 1'b0;
        @(posedge clk_i); #1 bus.out_ready = 1'b1;
        check_seq("B_words", words, exp_w);
        check_seq("B_addr", addrs, exp_a);

        // All-zero matrix writes only the terminator
        clear_logs();
        stim = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        exp_w = '{32'h000};
        exp_a = '{32'd0, 32'd0};
        run_matrix(4'd3, stim);
        wait_done("C_done", 1);
        check_seq("C_words", words, exp_w);
        check_seq("C_addr", addrs, exp_a);

        // 120 nonzero values into a 100-word spad
        clear_logs();
        exp_w.delete();
        pulse_start(4'd15);
        for (int i = 0; i < 120; i++) begin
            send(8'((i % 100) + 1), (i == 119));
            if (i < 99) exp_w.push_back(32'({8'((i % 100) + 1), 4'(i % 16)}));
            if (i == 98) check_eq("D_ovf_before", 32'(bus.overflow), 0);
            if (i == 99) check_eq("D_ovf_at_100", 32'(bus.overflow), 1);
        end
        exp_w.push_back(32'h000);
        wait_done("D_done", 1);
        check_seq("D_words", words, exp_w);
        exp_a = '{32'd16, 32'd32, 32'd48, 32'd64, 32'd80, 32'd96, 32'd99, 32'd99};
        check_seq("D_addr", addrs, exp_a);
        check_eq("D_ovf_sticky", 32'(bus.overflow), 1);

        // Reset mid-matrix, then a 1x1 matrix
        clear_logs();
        pulse_start(4'd3);
        check_eq("E_ovf_cleared", 32'(bus.overflow), 0);
        send(8'd1, 1'b0);
        send(8'd2, 1'b0);
        send(8'd3, 1'b0);
        for (int i = 0; i < 50 && words.size() < 3; i++) @(negedge clk_i);
        check_eq("E_words_before_rst", 32'(words.size()), 3);
        @(posedge clk_i); #2 rst_ni = 1'b0;
        #1;
        check_eq("E_rst_outs", 32'({bus.out_valid, bus.in_ready, bus.addr_valid, bus.done, bus.overflow, bus.busy}), 0);
        check_eq("E_rst_data", 32'({bus.out_data, bus.addr_data}), 0);
        @(posedge clk_i); #1 rst_ni = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("E_idle_after_rst", 32'({bus.busy, bus.out_valid}), 0);
        clear_logs();
        stim = '{8'd9};
        exp_w = '{32'h090, 32'h000};
        run_matrix(4'd0, stim);
        wait_done("E_done", 1);
        check_seq("E_words", words, exp_w);

        // Start and cfg_row_max changes while busy are ignored
        clear_logs();
        pulse_start(4'd1);
        send(8'd1, 1'b0);
        pulse_start(4'd0);
        check_eq("F_busy", 32'(bus.busy), 1);
        send(8'd2, 1'b0);
        send(8'd3, 1'b1);
        wait_done("F_done", 1);
        exp_w = '{32'h010, 32'h021, 32'h030, 32'h000};
        exp_a = '{32'd2, 32'd3};
        check_seq("F_words", words, exp_w);
        check_seq("F_addr", addrs, exp_a);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
